// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle unsigned 32-bit MUL / DIVU / REMU controller that borrows the
// execute-stage ALU while busy. It has no arithmetic of its own: every
// iteration is one ALU operation, and alu_result is captured on the same edge.
//
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   start, op           request (00 MUL, 01 DIVU, 10 REMU, 11 reserved)
//   operand_a/b         operands, sampled on accept (IDLE or DONE)
//   busy, done          busy in work states; done is a one-cycle pulse
//   result, div_by_zero registered outcome, held until the next accept
//   alu_a/b, alu_ctrl   ALU drive (000 add, 001 sub, 111 signed slt)
//   alu_result          combinational ALU output
//
// Build option: MULDIV_EARLY_OUT_EN ends a MUL once the remaining multiplier
// bits are all zero (b=0 finishes straight from accept).
//
// state   | meaning
// IDLE    | waiting for start
// MUL_ADD | shift-add step: acc += mplier[0] ? mcand : 0
// DIV_CMP | shift next dividend bit into rem, compare rem >= d
// DIV_SUB | conditional rem -= d, set quotient bit
// DONE    | result valid, done pulse; may accept a new request

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  generate
    if (WIDTH != 32) begin : g_width_check
      $error("muldiv_sequencer: only WIDTH=32 is supported");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL_ADD = 3'd1,
    S_DIV_CMP = 3'd2,
    S_DIV_SUB = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [1:0]       op_r;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] rem, q, d;
  logic             ge;

  logic [WIDTH-1:0] rem_s, rem_nxt, q_nxt, mplier_sh;
  logic             last_iter;

  assign busy = (state == S_MUL_ADD) || (state == S_DIV_CMP) || (state == S_DIV_SUB);
  assign done = (state == S_DONE);

  assign rem_s     = {rem[WIDTH-2:0], q[WIDTH-1]};
  assign rem_nxt   = ge ? alu_result : rem;
  assign q_nxt     = {q[WIDTH-1:1], ge};
  assign mplier_sh = mplier >> 1;
  assign last_iter = (cnt == 6'd31);

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = 3'b000;
    case (state)
      S_MUL_ADD: begin
        alu_a    = acc;
        alu_b    = mplier[0] ? mcand : '0;
        alu_ctrl = 3'b000;
      end
      S_DIV_CMP: begin
        // Flipping both sign bits turns the signed SLT into an unsigned compare.
        alu_a    = rem_s ^ SIGN_BIT;
        alu_b    = d ^ SIGN_BIT;
        alu_ctrl = 3'b111;
      end
      S_DIV_SUB: begin
        alu_a    = rem;
        alu_b    = d;
        alu_ctrl = 3'b001;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      op_r        <= 2'b00;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      rem         <= '0;
      q           <= '0;
      d           <= '0;
      ge          <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_r        <= op;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            case (op)
              2'b00: begin
                acc    <= '0;
                mcand  <= operand_a;
                mplier <= operand_b;
`ifdef MULDIV_EARLY_OUT_EN
                if (operand_b == '0) begin
                  result <= '0;
                  state  <= S_DONE;
                end else begin
                  state  <= S_MUL_ADD;
                end
`else
                state  <= S_MUL_ADD;
`endif
              end
              2'b01, 2'b10: begin
                if (operand_b == '0) begin
                  div_by_zero <= 1'b1;
                  result      <= (op == 2'b01) ? '1 : operand_a;
                  state       <= S_DONE;
                end else begin
                  rem   <= '0;
                  q     <= operand_a;
                  d     <= operand_b;
                  state <= S_DIV_CMP;
                end
              end
              default: begin
                result <= '0;
                state  <= S_DONE;
              end
            endcase
          end else begin
            state <= S_IDLE;
          end
        end

        S_MUL_ADD: begin
          acc    <= alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier_sh;
          cnt    <= cnt + 6'd1;
`ifdef MULDIV_EARLY_OUT_EN
          if (last_iter || (mplier_sh == '0)) begin
`else
          if (last_iter) begin
`endif
            result <= alu_result;
            state  <= S_DONE;
          end
        end

        S_DIV_CMP: begin
          // rem[31] is the bit shifted out of rem_s; if set, rem_s exceeds d.
          ge    <= rem[WIDTH-1] | ~alu_result[0];
          rem   <= rem_s;
          q     <= {q[WIDTH-2:0], 1'b0};
          state <= S_DIV_SUB;
        end

        S_DIV_SUB: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          cnt <= cnt + 6'd1;
          if (last_iter) begin
            result <= (op_r == 2'b01) ? q_nxt : rem_nxt;
            state  <= S_DONE;
          end else begin
            state  <= S_DIV_CMP;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a behavioural single-cycle ALU.
// Latency is counted in edges from the accepting edge (accept edge = 1).

module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        busy, done, div_by_zero;
  logic [31:0] result, alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;

  int n_vec = 0;
  int n_err = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_B6   = 4;
  localparam int LAT_BFF  = 33;
  localparam int LAT_B2   = 3;
  localparam int LAT_B5   = 4;
`else
  localparam int LAT_B6   = 33;
  localparam int LAT_BFF  = 33;
  localparam int LAT_B2   = 33;
  localparam int LAT_B5   = 33;
`endif

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result)
  );

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b111:  alu_result = {31'b0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(inout int cycles);
    while (!done && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cycles);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = x; operand_b = y;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    wait_done(cycles);
  endtask

  initial begin
    int cyc;
    int pulses;

    reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_dbz",    32'(div_by_zero), 32'd0);
    check("rst_alu_a",  alu_a, 32'd0);
    check("rst_alu_b",  alu_b, 32'd0);
    check("rst_ctrl",   32'(alu_ctrl), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Multiply
    run_op(2'b00, 32'd7, 32'd6, cyc);
    check("mul7x6_res", result, 32'd42);
    check("mul7x6_lat", 32'(cyc), 32'(LAT_B6));
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    check("mulff_res", result, 32'h0000_0001);
    check("mulff_lat", 32'(cyc), 32'(LAT_BFF));
    run_op(2'b00, 32'h8000_0000, 32'd2, cyc);
    check("mulovf_res", result, 32'h0000_0000);
    check("mulovf_lat", 32'(cyc), 32'(LAT_B2));

    // Divide / remainder
    run_op(2'b01, 32'd100, 32'd7, cyc);
    check("divu100_7_res", result, 32'd14);
    check("divu100_7_lat", 32'(cyc), 32'd65);
    check("divu100_7_dbz", 32'(div_by_zero), 32'd0);
    run_op(2'b10, 32'd100, 32'd7, cyc);
    check("remu100_7_res", result, 32'd2);
    check("remu100_7_lat", 32'(cyc), 32'd65);
    @(posedge clk); #1;
    check("pulse_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, cyc);
    check("divu_ff_1", result, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("remu_big", result, 32'h8000_0000);

    // Zero divisor and reserved op
    run_op(2'b01, 32'd5, 32'd0, cyc);
    check("divu_z_res", result, 32'hFFFF_FFFF);
    check("divu_z_dbz", 32'(div_by_zero), 32'd1);
    check("divu_z_lat", 32'(cyc), 32'd1);
    run_op(2'b10, 32'd5, 32'd0, cyc);
    check("remu_z_res", result, 32'd5);
    check("remu_z_dbz", 32'(div_by_zero), 32'd1);
    check("remu_z_lat", 32'(cyc), 32'd1);
    run_op(2'b11, 32'd9, 32'd3, cyc);
    check("rsvd_res", result, 32'd0);
    check("rsvd_dbz", 32'(div_by_zero), 32'd0);
    check("rsvd_lat", 32'(cyc), 32'd1);

    // Start during DIV_CMP is ignored
    @(negedge clk);
    start = 1'b1; op = 2'b01; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    check("div_busy", 32'(busy), 32'd1);
    check("div_cmp_ctrl", 32'(alu_ctrl), 32'd7);
    check("div_cmp_alu_a", alu_a, 32'h8000_0000);
    check("div_cmp_alu_b", alu_b, 32'h8000_0007);
    repeat (4) begin @(posedge clk); #1; cyc++; end
    check("mid_in_cmp", 32'(alu_ctrl), 32'd7);
    @(negedge clk);
    start = 1'b1; op = 2'b10; operand_a = 32'd50; operand_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; cyc++;
    wait_done(cyc);
    check("ignore_start_res", result, 32'd14);
    check("ignore_start_lat", 32'(cyc), 32'd65);

    // Reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'd7; operand_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_done",   32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_alu_a",  alu_a, 32'd0);
    check("abort_alu_b",  alu_b, 32'd0);
    check("abort_ctrl",   32'(alu_ctrl), 32'd0);
    @(negedge clk); reset = 1'b0;
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
    check("abort_no_done", 32'(pulses), 32'd0);

    // Back-to-back: start held through DONE
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'd3; operand_b = 32'd5;
    @(posedge clk); #1;
    cyc = 1;
    wait_done(cyc);
    check("b2b_mul_res", result, 32'd15);
    check("b2b_mul_lat", 32'(cyc), 32'(LAT_B5));
    op = 2'b01; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_drop", 32'(done), 32'd0);
    check("b2b_busy_rise", 32'(busy), 32'd1);
    cyc = 1;
    wait_done(cyc);
    check("b2b_div_res", result, 32'd14);
    check("b2b_div_lat", 32'(cyc), 32'd65);
    pulses = 0;
    repeat (10) begin @(posedge clk); #1; if (done) pulses++; end
    check("b2b_no_extra", 32'(pulses), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
